divider_16x8: RTL

Sequential restoring divider that inverts the 8x8 multiplier datapath. It takes a 16-bit product-width dividend and an 8-bit divisor, and returns a 16-bit quotient and an 8-bit remainder. It resolves one quotient bit per clock, using a start/busy/done handshake. It sits beside the multiplier in the arithmetic unit, and operand width conventions match: 8-bit operands, 16-bit wide result.

---
 rtl/divider_pkg.sv | 22 ++
 rtl/divider_16x8_div_step.sv | 29 ++
 rtl/divider_16x8.sv | 115 +++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// ============================================================
// divider_pkg : shared widths, FSM encoding and constants
// Revision 1.0
// ============================================================
`default_nettype none

package divider_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int CNT_W      = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = {DIVIDEND_W{1'b1}};

endpackage

`default_nettype wire

// File: rtl/divider_16x8_div_step.sv
// ============================================================
// div_step : one restoring shift/subtract/select iteration
// Revision 1.0
// ============================================================
`default_nettype none

module div_step #(
  parameter int DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   partial,
  input  logic                 in_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   next_partial,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;

  // Partial remainder stays below the divisor, so its top bit is always 0
  // and the shifted value fits in DIVISOR_W+1 bits.
  always_comb begin
    shifted      = {partial[DIVISOR_W-1:0], in_bit};
    q_bit        = ({partial, in_bit} >= {2'b00, divisor});
    next_partial = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

`default_nettype wire

// File: rtl/divider_16x8.sv
// ============================================================
// divider_16x8 : 16/8 unsigned restoring divider, 1 bit/clk
// Revision 1.0
// ============================================================
`default_nettype none

module divider_16x8 #(
  parameter int DIVIDEND_W = divider_pkg::DIVIDEND_W,
  parameter int DIVISOR_W  = divider_pkg::DIVISOR_W,
  parameter int CNT_W      = divider_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  import divider_pkg::*;

  state_t                state;
  state_t                next_state;
  logic [DIVIDEND_W-1:0] qreg;
  logic [DIVISOR_W:0]    partial;
  logic [DIVISOR_W-1:0]  dvsr;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    step_partial;
  logic                  step_bit;
  logic                  last_iter;
  logic                  accept;
  logic                  zero_div;

  assign last_iter = (cnt == CNT_W'(1));
  assign accept    = (state == IDLE) && start;
  assign zero_div  = (divisor == '0);

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .partial      (partial),
    .in_bit       (qreg[DIVIDEND_W-1]),
    .divisor      (dvsr),
    .next_partial (step_partial),
    .q_bit        (step_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && !zero_div) next_state = RUN;
      RUN:  if (last_iter)          next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
  end

  // Result registers are written only on completion, so they hold the
  // previous answer across the whole next run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qreg        <= '0;
      partial     <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (zero_div) begin
          done        <= 1'b1;
          div_by_zero <= 1'b1;
          quotient    <= DBZ_QUOTIENT;
          remainder   <= dividend[DIVISOR_W-1:0];
        end else begin
          qreg    <= dividend;
          partial <= '0;
          dvsr    <= divisor;
          cnt     <= CNT_W'(DIVIDEND_W);
        end
      end else if (state == RUN) begin
        qreg    <= {qreg[DIVIDEND_W-2:0], step_bit};
        partial <= step_partial;
        cnt     <= cnt - CNT_W'(1);
        if (last_iter) begin
          done        <= 1'b1;
          div_by_zero <= 1'b0;
          quotient    <= {qreg[DIVIDEND_W-2:0], step_bit};
          remainder   <= step_partial[DIVISOR_W-1:0];
        end
      end
    end
  end

endmodule

`default_nettype wire
